// File: rtl/debug_sba_master.sv
// System Bus Access engine: runs one checked debug read/write on the core memory bus.
// Optional build macro SBA_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on bus transactions.

package debug;
  typedef enum logic [2:0] {
    SBA_8  = 3'd0,
    SBA_16 = 3'd1,
    SBA_32 = 3'd2
  } sbaccess_e;

  typedef enum logic [2:0] {
    SBERR_NONE    = 3'd0,
    SBERR_TIMEOUT = 3'd1,
    SBERR_BADADDR = 3'd2,
    SBERR_ALIGN   = 3'd3,
    SBERR_SIZE    = 3'd4,
    SBERR_OTHER   = 3'd7
  } sberr_e;
endpackage

module debug_sba_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [31:0]       sb_iAddr,
  input  logic [31:0]       sb_iData,
  input  logic              sb_iRead,
  input  logic              sb_iWrite,
  input  debug::sbaccess_e  sb_iWidth,
  output logic              sb_oBusy,
  output debug::sberr_e     sb_oErr,
  output logic [31:0]       sb_oData,
  output logic              mem_oValid,
  input  logic              mem_iReady,
  output logic [31:0]       mem_oAddr,
  output logic              mem_oWrite,
  output logic [31:0]       mem_oData,
  output logic [3:0]        mem_oStrb,
  input  logic              mem_iRValid,
  input  logic [31:0]       mem_iRData,
  input  logic              mem_iErr
);
  import debug::*;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  strb_q;
  logic        write_q, early_q;
  sbaccess_e   width_q;
  sberr_e      err_q;

  sberr_e      cmdErr;
  logic        cmdOne, cmdBoth, cmdGo;
  logic [3:0]  laneStrb;
  logic [31:0] laneData, shifted, extracted;
  logic        respTake, handshake, timeoutHit, timeoutFire;

  assign cmdOne    = sb_iRead ^ sb_iWrite;
  assign cmdBoth   = sb_iRead & sb_iWrite;
  assign cmdGo     = (state_q == IDLE) && cmdOne && (cmdErr == SBERR_NONE);
  assign handshake = (state_q == REQ) && mem_iReady;
  assign respTake  = (handshake && mem_iRValid) || ((state_q == RESP) && mem_iRValid);
  assign timeoutFire = timeoutHit && !respTake && !handshake;

  // Width is checked before alignment so an unsupported size never reports ALIGN.
  always_comb begin
    cmdErr = SBERR_NONE;
    case (sb_iWidth)
      SBA_8:   cmdErr = SBERR_NONE;
      SBA_16:  if (sb_iAddr[0]) cmdErr = SBERR_ALIGN;
      SBA_32:  if (sb_iAddr[1:0] != 2'b00) cmdErr = SBERR_ALIGN;
      default: cmdErr = SBERR_SIZE;
    endcase
  end

  always_comb begin
    laneStrb = 4'hF;
    laneData = sb_iData;
    case (sb_iWidth)
      SBA_8: begin
        laneStrb = 4'b0001 << sb_iAddr[1:0];
        laneData = {4{sb_iData[7:0]}};
      end
      SBA_16: begin
        laneStrb = 4'b0011 << sb_iAddr[1:0];
        laneData = {2{sb_iData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = mem_iRData >> {addr_q[1:0], 3'b000};
    extracted = shifted;
    case (width_q)
      SBA_8:   extracted = {24'h0, shifted[7:0]};
      SBA_16:  extracted = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

`ifdef SBA_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cmdGo) cnt_d = '0;
    else if ((state_q == REQ) || (state_q == RESP)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeoutHit = ((state_q == REQ) || (state_q == RESP)) &&
                      (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the parameter has no effect; the expression is constant zero.
  assign timeoutHit = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmdBoth)     state_d = DONE;
        else if (cmdOne) state_d = (cmdErr == SBERR_NONE) ? REQ : DONE;
      end
      REQ: begin
        if (handshake)        state_d = mem_iRValid ? DONE : RESP;
        else if (timeoutHit)  state_d = DONE;
      end
      RESP: begin
        if (mem_iRValid || timeoutHit) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_oValid = (state_q == REQ);
    sb_oBusy   = (state_q == REQ) || (state_q == RESP) || ((state_q == DONE) && early_q);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      early_q <= 1'b0;
      width_q <= SBA_8;
      err_q   <= SBERR_NONE;
    end else begin
      if (state_q == IDLE) begin
        if (cmdBoth) begin
          err_q   <= SBERR_OTHER;
          early_q <= 1'b1;
        end else if (cmdOne) begin
          err_q   <= cmdErr;
          early_q <= (cmdErr != SBERR_NONE);
          if (cmdErr == SBERR_NONE) begin
            addr_q  <= sb_iAddr;
            wdata_q <= laneData;
            strb_q  <= laneStrb;
            write_q <= sb_iWrite;
            width_q <= sb_iWidth;
          end
        end
      end
      if (respTake) begin
        if (mem_iErr)      err_q   <= SBERR_BADADDR;
        else if (!write_q) rdata_q <= extracted;
      end else if (timeoutFire) begin
        err_q <= SBERR_TIMEOUT;
      end
      if (state_q == DONE) early_q <= 1'b0;
    end
  end

  assign sb_oErr    = err_q;
  assign sb_oData   = rdata_q;
  assign mem_oAddr  = {addr_q[31:2], 2'b00};
  assign mem_oWrite = write_q;
  assign mem_oData  = wdata_q;
  assign mem_oStrb  = strb_q;

endmodule

// File: tb/tb_debug_sba_master.sv
// Directed bench for debug_sba_master; the timeout scenario runs only when SBA_TIMEOUT_EN is defined.

module tb_debug_sba_master;
  logic             iClk = 1'b0;
  logic             iRst_n;
  logic [31:0]      sb_iAddr, sb_iData;
  logic             sb_iRead, sb_iWrite;
  debug::sbaccess_e sb_iWidth;
  logic             sb_oBusy;
  debug::sberr_e    sb_oErr;
  logic [31:0]      sb_oData;
  logic             mem_oValid, mem_iReady;
  logic [31:0]      mem_oAddr;
  logic             mem_oWrite;
  logic [31:0]      mem_oData;
  logic [3:0]       mem_oStrb;
  logic             mem_iRValid;
  logic [31:0]      mem_iRData;
  logic             mem_iErr;

  int vectors = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  debug_sba_master #(.TIMEOUT_CYCLES(16)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .sb_iAddr(sb_iAddr), .sb_iData(sb_iData), .sb_iRead(sb_iRead), .sb_iWrite(sb_iWrite),
    .sb_iWidth(sb_iWidth), .sb_oBusy(sb_oBusy), .sb_oErr(sb_oErr), .sb_oData(sb_oData),
    .mem_oValid(mem_oValid), .mem_iReady(mem_iReady), .mem_oAddr(mem_oAddr),
    .mem_oWrite(mem_oWrite), .mem_oData(mem_oData), .mem_oStrb(mem_oStrb),
    .mem_iRValid(mem_iRValid), .mem_iRData(mem_iRData), .mem_iErr(mem_iErr)
  );

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] w);
    sb_iRead  = rd;
    sb_iWrite = wr;
    sb_iAddr  = a;
    sb_iData  = d;
    sb_iWidth = debug::sbaccess_e'(w);
    tick();
    sb_iRead  = 1'b0;
    sb_iWrite = 1'b0;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({sb_oBusy, mem_oValid, mem_oWrite} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags busy/valid/write got %b expected 000",
               {sb_oBusy, mem_oValid, mem_oWrite});
    end
    vectors++;
    if (sb_oErr !== debug::SBERR_NONE || sb_oData !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_sb err=%0d data=%h expected 0/00000000", sb_oErr, sb_oData);
    end
    vectors++;
    if (mem_oAddr !== 32'h0 || mem_oData !== 32'h0 || mem_oStrb !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem addr=%h data=%h strb=%h expected zeros",
               mem_oAddr, mem_oData, mem_oStrb);
    end
    iRst_n = 1'b1;
    tick();
  endtask

  task automatic test_read32();
    int busyCycles = 0;
    mem_iReady = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'd2);
    vectors++;
    if (mem_oValid !== 1'b1 || mem_oStrb !== 4'hF || mem_oAddr !== 32'h1000 || mem_oWrite !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read32_req valid=%b strb=%h addr=%h wr=%b expected 1/f/00001000/0",
               mem_oValid, mem_oStrb, mem_oAddr, mem_oWrite);
    end
    if (sb_oBusy) busyCycles++;
    tick();
    if (sb_oBusy) busyCycles++;
    mem_iRValid = 1'b1;
    mem_iRData  = 32'hDEAD_BEEF;
    tick();
    mem_iRValid = 1'b0;
    if (sb_oBusy) busyCycles++;
    vectors++;
    if (sb_oData !== 32'hDEAD_BEEF || sb_oErr !== debug::SBERR_NONE) begin
      miscompares++;
      $display("[TB] FAIL read32_data data=%h err=%0d expected deadbeef/0", sb_oData, sb_oErr);
    end
    tick();
    if (sb_oBusy) busyCycles++;
    vectors++;
    if (busyCycles !== 2) begin
      miscompares++;
      $display("[TB] FAIL read32_busy busy cycles=%0d expected 2", busyCycles);
    end
  endtask

  task automatic test_byte_write_read();
    issue(1'b0, 1'b1, 32'h0000_2003, 32'h0000_00A5, 3'd0);
    vectors++;
    if (mem_oAddr !== 32'h2000 || mem_oStrb !== 4'b1000 || mem_oData !== 32'hA5A5_A5A5 ||
        mem_oWrite !== 1'b1 || mem_oValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL byte_write_req addr=%h strb=%b data=%h wr=%b valid=%b expected 00002000/1000/a5a5a5a5/1/1",
               mem_oAddr, mem_oStrb, mem_oData, mem_oWrite, mem_oValid);
    end
    mem_iRValid = 1'b1;
    mem_iRData  = 32'h0;
    tick();
    mem_iRValid = 1'b0;
    vectors++;
    if (sb_oBusy !== 1'b0 || mem_oValid !== 1'b0 || sb_oErr !== debug::SBERR_NONE ||
        sb_oData !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL byte_write_done busy=%b valid=%b err=%0d data=%h expected 0/0/0/deadbeef",
               sb_oBusy, mem_oValid, sb_oErr, sb_oData);
    end
    tick();
    issue(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'd0);
    vectors++;
    if (mem_oStrb !== 4'b1000 || mem_oWrite !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL byte_read_req strb=%b wr=%b expected 1000/0", mem_oStrb, mem_oWrite);
    end
    tick();
    mem_iRValid = 1'b1;
    mem_iRData  = 32'hA500_0000;
    tick();
    mem_iRValid = 1'b0;
    vectors++;
    if (sb_oData !== 32'h0000_00A5) begin
      miscompares++;
      $display("[TB] FAIL byte_read_data got %h expected 000000a5", sb_oData);
    end
    tick();
  endtask

  task automatic test_early_errors();
    logic sawValid;
    issue(1'b1, 1'b0, 32'h0000_1001, 32'h0, 3'd1);
    sawValid = mem_oValid;
    vectors++;
    if (sb_oErr !== debug::SBERR_ALIGN || sb_oBusy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL align_err err=%0d busy=%b expected 3/1", sb_oErr, sb_oBusy);
    end
    tick();
    sawValid = sawValid | mem_oValid;
    vectors++;
    if (sb_oBusy !== 1'b0 || sawValid !== 1'b0 || sb_oData !== 32'h0000_00A5) begin
      miscompares++;
      $display("[TB] FAIL align_after busy=%b valid_seen=%b data=%h expected 0/0/000000a5",
               sb_oBusy, sawValid, sb_oData);
    end
    issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'd3);
    vectors++;
    if (sb_oErr !== debug::SBERR_SIZE || mem_oValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL size_err err=%0d valid=%b expected 4/0", sb_oErr, mem_oValid);
    end
    tick();
    issue(1'b1, 1'b1, 32'h0000_1000, 32'h0, 3'd2);
    vectors++;
    if (sb_oErr !== debug::SBERR_OTHER || mem_oValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL both_err err=%0d valid=%b expected 7/0", sb_oErr, mem_oValid);
    end
    tick();
    issue(1'b0, 1'b1, 32'h0000_1002, 32'h0, 3'd1);
    vectors++;
    if (mem_oValid !== 1'b1 || mem_oStrb !== 4'b1100 || sb_oErr !== debug::SBERR_NONE) begin
      miscompares++;
      $display("[TB] FAIL half_upper valid=%b strb=%b err=%0d expected 1/1100/0",
               mem_oValid, mem_oStrb, sb_oErr);
    end
    mem_iRValid = 1'b1;
    tick();
    mem_iRValid = 1'b0;
    tick();
  endtask

  task automatic test_stall_buserr();
    mem_iReady = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_3002, 32'h0000_1234, 3'd1);
    for (int i = 0; i < 5; i++) begin
      sb_iRead = (i == 0);
      tick();
      sb_iRead = 1'b0;
      vectors++;
      if (mem_oValid !== 1'b1 || mem_oAddr !== 32'h3000 || mem_oStrb !== 4'b1100 ||
          mem_oData !== 32'h1234_1234 || mem_oWrite !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d] valid=%b addr=%h strb=%b data=%h wr=%b expected 1/00003000/1100/12341234/1",
                 i, mem_oValid, mem_oAddr, mem_oStrb, mem_oData, mem_oWrite);
      end
    end
    mem_iReady = 1'b1;
    tick();
    vectors++;
    if (mem_oValid !== 1'b0 || sb_oBusy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_resp valid=%b busy=%b expected 0/1", mem_oValid, sb_oBusy);
    end
    mem_iRValid = 1'b1;
    mem_iErr    = 1'b1;
    tick();
    mem_iRValid = 1'b0;
    mem_iErr    = 1'b0;
    vectors++;
    if (sb_oErr !== debug::SBERR_BADADDR || sb_oData !== 32'h0000_00A5 || sb_oBusy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL buserr err=%0d data=%h busy=%b expected 2/000000a5/0",
               sb_oErr, sb_oData, sb_oBusy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'd2);
    tick();
    vectors++;
    if (sb_oBusy !== 1'b1 || mem_oValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_resp busy=%b valid=%b expected 1/0", sb_oBusy, mem_oValid);
    end
    iRst_n = 1'b0;
    tick();
    vectors++;
    if ({sb_oBusy, mem_oValid, mem_oWrite} !== 3'b000 || sb_oErr !== debug::SBERR_NONE ||
        sb_oData !== 32'h0 || mem_oAddr !== 32'h0 || mem_oData !== 32'h0 || mem_oStrb !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset busy=%b valid=%b err=%0d data=%h addr=%h strb=%h expected zeros",
               sb_oBusy, mem_oValid, sb_oErr, sb_oData, mem_oAddr, mem_oStrb);
    end
    iRst_n      = 1'b1;
    mem_iRValid = 1'b1;
    mem_iRData  = 32'h1111_1111;
    tick();
    mem_iRValid = 1'b0;
    vectors++;
    if (sb_oBusy !== 1'b0 || sb_oData !== 32'h0 || sb_oErr !== debug::SBERR_NONE) begin
      miscompares++;
      $display("[TB] FAIL stray_rvalid busy=%b data=%h err=%0d expected 0/00000000/0",
               sb_oBusy, sb_oData, sb_oErr);
    end
    issue(1'b1, 1'b0, 32'h0000_4002, 32'h0, 3'd1);
    tick();
    mem_iRValid = 1'b1;
    mem_iRData  = 32'hBEEF_0000;
    tick();
    mem_iRValid = 1'b0;
    vectors++;
    if (sb_oData !== 32'h0000_BEEF || sb_oErr !== debug::SBERR_NONE) begin
      miscompares++;
      $display("[TB] FAIL after_reset_read data=%h err=%0d expected 0000beef/0", sb_oData, sb_oErr);
    end
    tick();
  endtask

`ifdef SBA_TIMEOUT_EN
  task automatic test_timeout();
    int waited = 1;
    mem_iReady = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'd2);
    while ((sb_oBusy || mem_oValid) && waited < 18) begin
      tick();
      waited++;
    end
    vectors++;
    if (sb_oBusy !== 1'b0 || mem_oValid !== 1'b0 || sb_oErr !== debug::SBERR_TIMEOUT) begin
      miscompares++;
      $display("[TB] FAIL timeout busy=%b valid=%b err=%0d after %0d cycles expected 0/0/1",
               sb_oBusy, mem_oValid, sb_oErr, waited);
    end
    mem_iReady  = 1'b1;
    mem_iRValid = 1'b1;
    tick();
    mem_iRValid = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'd2);
    tick();
    mem_iRValid = 1'b1;
    mem_iRData  = 32'h0BAD_F00D;
    tick();
    mem_iRValid = 1'b0;
    vectors++;
    if (sb_oData !== 32'h0BAD_F00D || sb_oErr !== debug::SBERR_NONE) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover data=%h err=%0d expected 0badf00d/0", sb_oData, sb_oErr);
    end
    tick();
  endtask
`endif

  initial begin
    iRst_n      = 1'b0;
    sb_iAddr    = '0;
    sb_iData    = '0;
    sb_iRead    = 1'b0;
    sb_iWrite   = 1'b0;
    sb_iWidth   = debug::SBA_8;
    mem_iReady  = 1'b0;
    mem_iRValid = 1'b0;
    mem_iRData  = '0;
    mem_iErr    = 1'b0;
    $display("[TB] starting debug_sba_master bench");
    test_reset();
    test_read32();
    test_byte_write_read();
    test_early_errors();
    test_stall_buserr();
    test_reset_mid();
`ifdef SBA_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
